model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns: RTL and testbench
===============================================================

Name: model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns

Overview:
- Sequential signed divider. It recovers the 13-bit unsigned operand from a 21-bit signed product and its 8-bit signed weight, which is the inverse of the 13ns x 8s -> 21s DSP multiply path.
- Used by the requantization / activation back-scaling stage of the hls4ml datapath.
- Restoring division on magnitudes, one quotient bit per enabled clock.
- Valid/ready handshakes on both sides; global ce stall.

Parameters:
- ID, 32'd1, instance identifier; no functional effect.
- DIN0_WIDTH, 21, dividend width (signed).
- DIN1_WIDTH, 8, divisor width (signed).
- DOUT_WIDTH, 13, quotient width (unsigned, saturated).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ce  in  1  clock enable; 0 freezes every register (state, counter, datapath, outputs).
- in_valid  in  1  din0/din1 valid.
- in_ready  out  1  block can accept an operand pair.
- din0  in  DIN0_WIDTH  signed dividend.
- din1  in  DIN1_WIDTH  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  DOUT_WIDTH  unsigned quotient, saturated.
- rem  out  DIN1_WIDTH  signed remainder; sign follows the dividend.
- sat  out  1  quotient clamped.
- dz  out  1  divide by zero.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, in_ready=0 while reset is asserted and 1 from the first edge after release, out_valid=0, dout=0, rem=0, sat=0, dz=0. Reset mid-operation abandons that operation; no output is produced for it.
- A transfer happens only on a rising edge with ce=1. Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0. On input transfer, latch |din0| into a 21-bit unsigned register, |din1| into an 8-bit unsigned register, sign of dividend, and sign_q = sign(din0) XOR sign(din1). Load counter=21, go to BUSY.
  - BUSY: in_ready=0. Each ce=1 edge performs one restoring step: shift the partial remainder left, bring in the next dividend MSB, trial-subtract the divisor magnitude, and set the quotient bit on no-borrow. Counter decrements by 1. When counter reaches 0, go to FIN.
  - FIN: single cycle. Apply sign and saturation rules, register dout/rem/sat/dz, set out_valid=1, go to DONE.
  - DONE: out_valid=1; outputs held stable. On output transfer, go to IDLE and drop out_valid. No new input is accepted in DONE.
- Latency: out_valid rises on the 22nd ce=1 edge after the input-transfer edge. Each ce=0 cycle adds one cycle. Throughput is at most one result per 23 cycles.
- Magnitudes: |-2^20| = 2^20 fits the 21-bit unsigned register; |-128| = 128 fits 8 bits unsigned. No overflow is possible inside the datapath.
- Quotient truncates toward zero. rem = sign(din0) * (|din0| mod |din1|); its magnitude is at most 127, so it fits 8s.
- Saturation of dout:
  - Raw quotient magnitude 0: dout=0, sat=0, whatever sign_q is.
  - sign_q=1 and magnitude nonzero: dout=0, sat=1.
  - sign_q=0 and magnitude > 8191: dout=8191, sat=1.
  - Otherwise dout = magnitude[12:0], sat=0.
- Divide by zero (din1=0): the iterations still run for the full latency. Result: dz=1, dout=8191, sat=1, rem=0.
- in_valid while not IDLE is ignored; the upstream must hold its data until it sees in_ready.
- out_ready=1 while out_valid=0 has no effect.

Test Plan:
1. din0=1000, din1=8, ce=1 -> out_valid on the 22nd edge after accept; dout=125, rem=0, sat=0, dz=0. Outputs hold while out_ready=0 for 5 cycles, then in_ready=1 on the edge after out_ready=1.
2. din0=-1000, din1=-7 -> dout=142, rem=-6, sat=0. Then din0=-1000, din1=7 -> dout=0, sat=1, rem=-6.
3. din0=1048575, din1=1 -> dout=8191, sat=1, rem=0. Then din0=-1048576, din1=-128 -> dout=8191, sat=1, rem=0 (quotient 8192).
4. din0=500, din1=0 -> dz=1, dout=8191, sat=1, rem=0, latency 22. Then din0=0, din1=-5 -> dout=0, sat=0, rem=0.
5. ce=0 for 5 cycles at iteration 10 of din0=1000, din1=8 -> out_valid arrives 27 edges after accept with dout=125. in_valid held during BUSY causes no second accept.
6. reset=0 asynchronously at iteration 10 -> out_valid=0 and dout=0 immediately, without waiting for an edge. After release, in_ready=1; a fresh din0=21, din1=4 gives dout=5, rem=1.

Source files
------------

// File: rtl/model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns.sv
// Sequential signed divider: recovers the 13-bit unsigned operand of a 13ns x 8s
// product by restoring division on magnitudes, one quotient bit per enabled clock.
module model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns #(
    parameter logic [31:0] ID         = 32'd1,
    parameter int          DIN0_WIDTH = 21,
    parameter int          DIN1_WIDTH = 8,
    parameter int          DOUT_WIDTH = 13
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         ce_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DIN0_WIDTH-1:0] din0_i,
    input  logic signed [DIN1_WIDTH-1:0] din1_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic        [DOUT_WIDTH-1:0] dout_o,
    output logic signed [DIN1_WIDTH-1:0] rem_o,
    output logic                         sat_o,
    output logic                         dz_o
);

    localparam int                    CNT_W    = $clog2(DIN0_WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DIN0_WIDTH);
    localparam logic [DOUT_WIDTH-1:0] SAT_MAX  = {DOUT_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIN0_WIDTH-1:0]   dvd_q;      // dividend bits shift out, quotient bits shift in
    logic [DIN1_WIDTH-1:0]   dvsr_q;
    logic [DIN1_WIDTH-1:0]   prem_q;
    logic                    sign_dvd_q;
    logic                    sign_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DOUT_WIDTH-1:0]   dout_q;
    logic [DIN1_WIDTH-1:0]   rem_q;
    logic                    sat_q;
    logic                    dz_q;

    logic [DIN0_WIDTH-1:0]   din0_u;
    logic [DIN1_WIDTH-1:0]   din1_u;
    logic [DIN0_WIDTH-1:0]   din0_mag;
    logic [DIN1_WIDTH-1:0]   din1_mag;
    logic [DIN1_WIDTH:0]     shifted;
    logic                    no_borrow;
    logic [DIN1_WIDTH-1:0]   diff_lo;
    logic [DIN1_WIDTH-1:0]   prem_d;
    logic                    q_ovf;
    logic [DIN1_WIDTH-1:0]   rem_d;

    always_comb begin
        din0_u    = din0_i;
        din1_u    = din1_i;
        din0_mag  = din0_u[DIN0_WIDTH-1] ? -din0_u : din0_u;
        din1_mag  = din1_u[DIN1_WIDTH-1] ? -din1_u : din1_u;
        shifted   = {prem_q, dvd_q[DIN0_WIDTH-1]};
        no_borrow = shifted >= {1'b0, dvsr_q};
        // On no-borrow the true difference is below the divisor, so the low bits are exact.
        diff_lo   = shifted[DIN1_WIDTH-1:0] - dvsr_q;
        prem_d    = no_borrow ? diff_lo : shifted[DIN1_WIDTH-1:0];
        q_ovf     = |dvd_q[DIN0_WIDTH-1:DOUT_WIDTH];
        rem_d     = sign_dvd_q ? -prem_q : prem_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvsr_q      <= '0;
            prem_q      <= '0;
            sign_dvd_q  <= 1'b0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            rem_q       <= '0;
            sat_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        dvd_q      <= din0_mag;
                        dvsr_q     <= din1_mag;
                        prem_q     <= '0;
                        sign_dvd_q <= din0_i[DIN0_WIDTH-1];
                        sign_q     <= din0_i[DIN0_WIDTH-1] ^ din1_i[DIN1_WIDTH-1];
                        cnt_q      <= CNT_LOAD;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[DIN0_WIDTH-2:0], no_borrow};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= FIN;
                end
                FIN: begin
                    if (dvsr_q == '0) begin
                        dout_q <= SAT_MAX;
                        rem_q  <= '0;
                        sat_q  <= 1'b1;
                        dz_q   <= 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        dz_q  <= 1'b0;
                        if (dvd_q == '0) begin
                            dout_q <= '0;
                            sat_q  <= 1'b0;
                        end else if (sign_q) begin
                            dout_q <= '0;
                            sat_q  <= 1'b1;
                        end else if (q_ovf) begin
                            dout_q <= SAT_MAX;
                            sat_q  <= 1'b1;
                        end else begin
                            dout_q <= dvd_q[DOUT_WIDTH-1:0];
                            sat_q  <= 1'b0;
                        end
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign rem_o       = rem_q;
    assign sat_o       = sat_q;
    assign dz_o        = dz_q;

endmodule

// File: tb/tb_model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns.sv
// Directed bench for the sequential signed divider: latency, sign/saturation rules,
// divide by zero, ce stall and asynchronous reset.
module tb_model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic signed [20:0] din0;
    logic signed [7:0]  din1;
    logic               out_valid;
    logic               out_ready;
    logic [12:0]        dout;
    logic signed [7:0]  rem;
    logic               sat;
    logic               dz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    model_nexys_hls4ml_prj_1_div_seq_21s_8s_13ns #(
        .ID(32'd1), .DIN0_WIDTH(21), .DIN1_WIDTH(8), .DOUT_WIDTH(13)
    ) dut (
        .clk_i(clk), .reset_i(reset), .ce_i(ce),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .din0_i(din0), .din1_i(din1),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .dout_o(dout), .rem_o(rem), .sat_o(sat), .dz_o(dz)
    );

    // Offer one operand pair, then count edges until out_valid (bounded).
    task automatic do_op(input int a, input int b, output int lat);
        @(negedge clk);
        din0 = 21'(a);
        din1 = 8'(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout !== 13'd0 || rem !== 8'sd0 || sat !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b dout=%0d rem=%0d sat=%b dz=%b exp all zero",
                     in_ready, out_valid, dout, rem, sat, dz);
        end
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rdy got %b exp 0 before first edge", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_rdy got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [12:0] held;
        int bad_hold = 0;
        do_op(1000, 8, lat);
        checks++;
        if (lat !== 22) begin errors++; $display("FAIL basic_latency got %0d exp 22", lat); end
        checks++;
        if (dout !== 13'd125 || rem !== 8'sd0 || sat !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got dout=%0d rem=%0d sat=%b dz=%b exp 125 0 0 0", dout, rem, sat, dz);
        end
        held = dout;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || dout !== 13'd125 || in_ready !== 1'b0) bad_hold++;
        end
        checks++;
        if (bad_hold !== 0) begin
            errors++;
            $display("FAIL basic_hold got %0d unstable cycles exp 0 (last dout=%0d held=%0d)", bad_hold, dout, held);
        end
        drain();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_signs();
        int a[2] = '{-1000, -1000};
        int b[2] = '{-7, 7};
        int e_dout[2] = '{142, 0};
        int e_sat[2] = '{0, 1};
        int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(a[i], b[i], lat);
            checks++;
            if (dout !== 13'(e_dout[i]) || int'(rem) !== -6 || sat !== 1'(e_sat[i]) || dz !== 1'b0) begin
                errors++;
                $display("FAIL signs_%0d got dout=%0d rem=%0d sat=%b dz=%b exp dout=%0d rem=-6 sat=%0d dz=0",
                         i, dout, rem, sat, dz, e_dout[i], e_sat[i]);
            end
            drain();
        end
    endtask

    task automatic test_saturation();
        int a[2] = '{1048575, -1048576};
        int b[2] = '{1, -128};
        int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(a[i], b[i], lat);
            checks++;
            if (dout !== 13'd8191 || rem !== 8'sd0 || sat !== 1'b1 || dz !== 1'b0) begin
                errors++;
                $display("FAIL sat_%0d got dout=%0d rem=%0d sat=%b dz=%b exp 8191 0 1 0", i, dout, rem, sat, dz);
            end
            drain();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(500, 0, lat);
        checks++;
        if (lat !== 22) begin errors++; $display("FAIL dz_latency got %0d exp 22", lat); end
        checks++;
        if (dz !== 1'b1 || dout !== 13'd8191 || sat !== 1'b1 || rem !== 8'sd0) begin
            errors++;
            $display("FAIL dz_result got dout=%0d rem=%0d sat=%b dz=%b exp 8191 0 1 1", dout, rem, sat, dz);
        end
        drain();
        do_op(0, -5, lat);
        checks++;
        if (dout !== 13'd0 || rem !== 8'sd0 || sat !== 1'b0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL zero_dividend got dout=%0d rem=%0d sat=%b dz=%b exp 0 0 0 0", dout, rem, sat, dz);
        end
        drain();
    endtask

    task automatic test_ce_stall();
        int lat = 0;
        int rdy_bad = 0;
        @(negedge clk);
        din0 = 21'sd1000;
        din1 = 8'sd8;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din0 = 21'sd77;
        din1 = 8'sd3;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 10) ce = 1'b0;
            if (lat == 15) ce = 1'b1;
            if (!out_valid && in_ready !== 1'b0) rdy_bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL stall_latency got %0d exp 27", lat); end
        checks++;
        if (rdy_bad !== 0) begin errors++; $display("FAIL stall_busy_ready got %0d ready cycles exp 0", rdy_bad); end
        checks++;
        if (dout !== 13'd125 || rem !== 8'sd0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL stall_result got dout=%0d rem=%0d sat=%b exp 125 0 0", dout, rem, sat);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        // Result 125 still held from the stalled operation.
        drain();
        @(negedge clk);
        din0 = 21'sd1000;
        din1 = 8'sd8;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        drive_dout_before_reset: begin end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 13'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got vld=%b dout=%0d rdy=%b exp 0 0 0", out_valid, dout, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        end
        do_op(21, 4, lat);
        checks++;
        if (lat !== 22 || dout !== 13'd5 || rem !== 8'sd1 || sat !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op got lat=%0d dout=%0d rem=%0d sat=%b exp 22 5 1 0", lat, dout, rem, sat);
        end
        drain();
    endtask

    initial begin
        reset = 1'b0;
        ce = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din0 = '0;
        din1 = '0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_zero();
        test_ce_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
